// File: rtl/tt_um_eldritch_pwm_peripheral.sv
// Three-channel PWM peripheral with a byte-wide register file.
// Each channel has a 16-bit period counter and two outputs (A/B). Every output
// has action qualifiers, compare values and a rise/fall deadband stage.
// Channel 1 is the sync master. Channels 2 and 3 can reload their count to a
// phase offset whenever the master's count reaches its period.
module tt_um_eldritch_pwm_peripheral (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int         NumRegs  = 49;
  localparam logic [5:0] LastAddr = 6'h30;

  logic       writeEn;
  logic       readEn;
  logic       readActive;
  logic [5:0] addr;
  logic [7:0] regFile_q [NumRegs];
  logic       syncPulse;
  logic [5:0] pwmPins;
  logic       unusedEna;

  assign writeEn    = ui_in[0];
  assign readEn     = ui_in[1];
  assign addr       = ui_in[7:2];
  assign readActive = readEn & ~writeEn;
  assign unusedEna  = ena;

  // Register file: a write lands on the addressed byte; addresses past the map are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regFile_q[i] <= '0;
    end else if (writeEn && (addr <= LastAddr)) begin
      regFile_q[addr] <= uio_in;
    end
  end

  // Read port is combinational; it only drives data while reading without a write
  always_comb begin
    uio_out = 8'h00;
    if (readActive && (addr <= LastAddr)) uio_out = regFile_q[addr];
  end

  assign uio_oe = readActive ? 8'hFF : 8'h00;
  assign uo_out = {2'b00, pwmPins};

  for (genvar c = 0; c < 3; c++) begin : g_chan
    // Channels 2/3 have a two-byte phase register after PERIOD, which shifts the rest of their map
    localparam int Base = (c == 0) ? 0 : ((c == 1) ? 15 : 32);
    localparam int Sh   = (c == 0) ? 0 : 2;

    logic [15:0] period;
    logic [15:0] phase;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        enable;
    logic        syncLoad;

    assign period = {regFile_q[Base+1], regFile_q[Base+2]};
    assign enable = regFile_q[Base][0];

    if (c == 0) begin : g_master
      assign phase     = 16'd0;
      assign syncLoad  = 1'b0;
      assign syncPulse = enable && (count_q == period);
    end else begin : g_slave
      assign phase    = {regFile_q[Base+3], regFile_q[Base+4]};
      assign syncLoad = regFile_q[Base][4] && syncPulse;
    end

    // Period counter: wraps after PERIOD, jumps to PHASE on sync, parks at zero while disabled
    always_comb begin
      count_d = count_q + 16'd1;
      if (!enable) begin
        count_d = 16'd0;
      end else if (syncLoad) begin
        count_d = (phase > period) ? 16'd0 : phase;
      end else if (count_q == period) begin
        count_d = 16'd0;
      end
    end

    // Counter state register
    always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
    end

    for (genvar o = 0; o < 2; o++) begin : g_out
      localparam int Off = Base + Sh + 6 * o;

      logic [7:0]  act;
      logic [7:0]  db;
      logic [15:0] cmpA;
      logic [15:0] cmpB;
      logic [1:0]  action;
      logic        raw_q;
      logic        raw_d;
      logic        dbOut_q;
      logic        dbOut_d;
      logic [3:0]  dbCnt_q;
      logic [3:0]  dbCnt_d;
      logic [3:0]  delay;

      assign act  = regFile_q[Off+3];
      assign cmpA = {regFile_q[Off+4], regFile_q[Off+5]};
      assign cmpB = {regFile_q[Off+6], regFile_q[Off+7]};
      assign db   = regFile_q[Off+8];

      // Pick the highest-priority non-idle action (CB over CA over PRD over ZERO) and apply it
      always_comb begin
        action = 2'b00;
        raw_d  = raw_q;
        if (enable) begin
          if ((count_q == 16'd0) && (act[1:0] != 2'b00)) action = act[1:0];
          if ((count_q == period) && (act[3:2] != 2'b00)) action = act[3:2];
          if ((count_q == cmpA) && (act[5:4] != 2'b00)) action = act[5:4];
          if ((count_q == cmpB) && (act[7:6] != 2'b00)) action = act[7:6];
        end
        case (action)
          2'b01:   raw_d = 1'b0;
          2'b10:   raw_d = 1'b1;
          2'b11:   raw_d = ~raw_q;
          default: raw_d = raw_q;
        endcase
        if (!enable) raw_d = 1'b0;
      end

      // Deadband: follow raw only after it has held its new level for the rise/fall delay
      always_comb begin
        dbOut_d = dbOut_q;
        dbCnt_d = 4'd0;
        delay   = raw_q ? db[7:4] : db[3:0];
        if (raw_q != dbOut_q) begin
          if (dbCnt_q >= delay) dbOut_d = raw_q;
          else                  dbCnt_d = dbCnt_q + 4'd1;
        end
      end

      // Raw output and deadband state registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          raw_q   <= 1'b0;
          dbOut_q <= 1'b0;
          dbCnt_q <= 4'd0;
        end else begin
          raw_q   <= raw_d;
          dbOut_q <= dbOut_d;
          dbCnt_q <= dbCnt_d;
        end
      end

      assign pwmPins[2*c+o] = dbOut_q & regFile_q[Base][1+o] & enable;
    end
  end

endmodule

// File: tb/tb_tt_um_eldritch_pwm_peripheral.sv
// Scoreboard bench for the PWM peripheral.
// The stimulus pushes expected pin and bus values, and a negedge monitor pops and compares them.
module tb_tt_um_eldritch_pwm_peripheral;

  // Expectation record. kind 0 = uo_out, 1 = uio_out, 2 = uio_oe
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] expVal;
  } expItem_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  expItem_t scoreQ[$];
  int       compared   = 0;
  int       mismatched = 0;

  always #5 clk = ~clk;

  tt_um_eldritch_pwm_peripheral dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  // Compare one expectation against the selected DUT output
  task automatic checkOutput(input expItem_t item);
    logic [7:0] actual;
    case (item.kind)
      0:       actual = uo_out;
      1:       actual = uio_out;
      default: actual = uio_oe;
    endcase
    compared++;
    if (actual !== item.expVal) begin
      mismatched++;
      $display("[TB] FAIL %s: got %02h, required %02h", item.name, actual, item.expVal);
    end
  endtask

  // Monitor: drain every expectation queued for the current cycle at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
    end
  end

  task automatic expectOut(input string name, input int kind, input logic [7:0] value);
    expItem_t item;
    item.name   = name;
    item.kind   = kind;
    item.expVal = value;
    scoreQ.push_back(item);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] data);
    ui_in  = ui;
    uio_in = data;
    step();
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic writeReg(input logic [5:0] addr, input logic [7:0] data);
    applyStimulus({addr, 2'b01}, data);
  endtask

  task automatic readCheck(input string name, input logic [5:0] addr, input logic [7:0] value);
    ui_in = {addr, 2'b10};
    expectOut(name, 1, value);
    expectOut({name, "Oe"}, 2, 8'hFF);
    step();
    ui_in = 8'h00;
  endtask

  // Expected pins by cycle k within the period (count == k), derived by hand:
  // A high for k = 2..9 (DB 0) or 5..9 (RED 3), B high outside 2..9,
  // PWM2A (count = k + 10) high for k = 24..31
  function automatic logic [7:0] expPins(input int mode, input int n);
    int         k;
    logic [7:0] pins;
    k       = n % 32;
    pins    = 8'h00;
    pins[1] = !((k >= 2) && (k <= 9));
    if (mode == 1) pins[0] = (k >= 5) && (k <= 9);
    else           pins[0] = (k >= 2) && (k <= 9);
    if (mode == 2) pins[2] = (k >= 24);
    return pins;
  endfunction

  task automatic runPhase(input int mode, input int cycles, input int startN);
    for (int n = 0; n < cycles; n++) begin
      if (n >= startN) expectOut($sformatf("pins_m%0d_n%0d", mode, n), 0, expPins(mode, n));
      step();
    end
  endtask

  task automatic quiesce(input string name);
    writeReg(6'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      expectOut(name, 0, 8'h00);
      step();
    end
  endtask

  // Main stimulus sequence
  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = {6'h08, 2'b01};
    uio_in = 8'h77;
    for (int i = 0; i < 8; i++) begin
      step();
      expectOut("rstUo", 0, 8'h00);
    end
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    for (int i = 0; i < 100; i++) begin
      expectOut("idleUo", 0, 8'h00);
      expectOut("idleOe", 2, 8'h00);
      step();
    end

    readCheck("rstPrioRd", 6'h08, 8'h00);
    writeReg(6'h08, 8'hA5);
    readCheck("rdDbA", 6'h08, 8'hA5);
    writeReg(6'h35, 8'h3C);
    readCheck("rdUnmapped", 6'h35, 8'h00);
    writeReg(6'h30, 8'h5A);
    readCheck("rdLast", 6'h30, 8'h5A);
    writeReg(6'h1E, 8'hC3);
    readCheck("rdPwm2", 6'h1E, 8'hC3);
    ui_in  = {6'h08, 2'b11};
    uio_in = 8'hA5;
    expectOut("wrPrioOe", 2, 8'h00);
    expectOut("wrPrioData", 1, 8'h00);
    step();
    ui_in  = 8'h00;
    uio_in = 8'h00;

    writeReg(6'h01, 8'h00);
    writeReg(6'h02, 8'h1F);
    writeReg(6'h03, 8'h12);
    writeReg(6'h04, 8'h00);
    writeReg(6'h05, 8'h08);
    writeReg(6'h08, 8'h00);
    writeReg(6'h09, 8'h21);
    writeReg(6'h0A, 8'h00);
    writeReg(6'h0B, 8'h08);
    writeReg(6'h0E, 8'h00);
    writeReg(6'h00, 8'h17);
    runPhase(0, 96, 32);

    quiesce("disable1");
    writeReg(6'h08, 8'h30);
    writeReg(6'h00, 8'h17);
    runPhase(1, 96, 32);

    quiesce("disable2");
    writeReg(6'h08, 8'h00);
    writeReg(6'h10, 8'h00);
    writeReg(6'h11, 8'h1F);
    writeReg(6'h12, 8'h00);
    writeReg(6'h13, 8'h0A);
    writeReg(6'h14, 8'h12);
    writeReg(6'h15, 8'h00);
    writeReg(6'h16, 8'h08);
    writeReg(6'h19, 8'h00);
    writeReg(6'h0F, 8'h17);
    writeReg(6'h00, 8'h17);
    runPhase(2, 192, 96);

    step();
    @(negedge clk);
    #1;
    if (scoreQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, required 0", scoreQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tt_um_eldritch_pwm_peripheral.md
TT_UM_ELDRITCH_PWM_PERIPHERAL -- requirements
Module: tt_um_eldritch_pwm_peripheral

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 ena  input  1  design-enable from harness; ignored by the block.
REQ-004 ui_in  input  8  [0]=write_en, [1]=read_en, [7:2]=register address (6 bits).
REQ-005 uio_in  input  8  write data bus.
REQ-006 uio_out  output  8  read data bus.
REQ-007 uio_oe  output  8  0xFF when read_en=1 and write_en=0, else 0x00.
REQ-008 uo_out  output  8  [0]=PWM1A, [1]=PWM1B, [2]=PWM2A, [3]=PWM2B, [4]=PWM3A, [5]=PWM3B, [7:6]=0 always.

Function
REQ-009 Write: on each clk edge with write_en=1, reg[addr] <= uio_in; write_en has priority over read_en; unmapped addresses 0x31-0x3F ignore writes.
REQ-010 Read: uio_out = reg[addr] combinationally when read_en=1 and write_en=0; otherwise 0; unmapped addresses read 0.
REQ-011 Map, PWM1: 0x00 CTRL, 0x01/0x02 PERIOD MSB/LSB, 0x03 ACT_A, 0x04/0x05 CMPA (for A), 0x06/0x07 CMPB (for A), 0x08 DB_A, 0x09 ACT_B, 0x0A/0x0B CMPA (for B), 0x0C/0x0D CMPB (for B), 0x0E DB_B; PWM1 has no phase register.
REQ-012 Map, PWM2 base 0x0F, PWM3 base 0x20: +0 CTRL, +1/+2 PERIOD, +3/+4 PHASE MSB/LSB, +5 ACT_A, +6..+9 CMPA/CMPB for A, +A DB_A, +B ACT_B, +C..+F CMPA/CMPB for B, +0x10 DB_B.
REQ-013 CTRL: bit0 counter enable, bit1 output A enable, bit2 output B enable, bit4 phase-sync enable (PWM2/3 only), bits 3,5-7 reserved (stored, no effect).
REQ-014 Counter: 16-bit up-counter; while enable=1 increments each clk; when count==PERIOD next count is 0; while enable=0 count held at 0.
REQ-015 Events per channel evaluated on current count: ZERO (count==0), PRD (count==PERIOD), CA (count==CMPA of that output), CB (count==CMPB of that output); events only while enable=1.
REQ-016 ACT byte per output: [1:0] on ZERO, [3:2] on PRD, [5:4] on CA, [7:6] on CB; code 00 none, 01 clear, 10 set, 11 toggle.
REQ-017 Raw output register updated on the edge following the event; simultaneous events: priority CB > CA > PRD > ZERO (highest-priority non-00 action applies).
REQ-018 Deadband DB byte: [7:4] rising-edge delay RED, [3:0] falling-edge delay FED, in clk cycles (0-15).
REQ-019 Deadband: output rises RED cycles after raw rises, only if raw still high; falls FED cycles after raw falls, only if raw still low; pulses shorter than the delay are suppressed; delay 0 = one-cycle register only.
REQ-020 Final pin = deadband output AND output-enable bit AND counter enable.
REQ-021 Sync: PWM1 generates a sync pulse when its count==PERIOD and enable=1; PWM2/3 with CTRL bit4=1 load count <= PHASE on the next edge instead of incrementing (PHASE > PERIOD loads 0).
REQ-022 Register writes take effect immediately (no shadowing); lowering enable mid-period clears count and raw outputs on next edge.

Reset
REQ-023 With rst_n=0 at a clk edge: all registers, counters, raw and deadband state = 0; uo_out=0x00, uio_out=0x00, uio_oe=0x00 from that edge until configured.
REQ-024 Reset has priority over write_en in the same cycle.

Verification
REQ-025 Reset 8 cycles, no writes -> uo_out=0x00, uio_oe=0x00 for 100 cycles.
REQ-026 PWM1: CTRL=0x17, PERIOD=0x001F, ACT_A=0x12, CMPA(A)=0x0008, DB_A=0x00 -> uo_out[0] high 8 cycles of every 32, period 32.
REQ-027 Same plus DB_A=0x30 -> uo_out[0] high 5 cycles per 32, rising edge 3 cycles later than REQ-026, falling edge unchanged.
REQ-028 PWM1 ACT_B=0x21, CMPA(B)=0x0008, DB_B=0 -> uo_out[1] exact complement of raw A: high 24 of 32 cycles.
REQ-029 PWM2 identical config to PWM1 plus PHASE=0x000A, CTRL bit4=1 -> after first PWM1 sync, PWM2A waveform leads/offset from PWM1A by 10 cycles, steady thereafter.
REQ-030 Write 0xA5 to 0x08, then read_en=1, write_en=0, addr 0x08 -> uio_oe=0xFF, uio_out=0xA5; addr 0x35 -> uio_out=0x00.
